spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into a 10-bit command/data word and pulses rx_valid.
- On a read-data frame, waits for the RAM's tx_valid/tx_data and serialises the 8-bit byte onto MISO, MSB first.
- The SPI serial clock is the system clock clk; MOSI and SS_n are already synchronous to clk.

Parameters:
- RX_W, 10, width of rx_data: 2-bit command + 8-bit address/data.
- TX_W, 8, width of tx_data and bits shifted out on MISO.

Ports:
- clk  input  1  system/SPI clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; frame boundary.
- MOSI  input  1  serial data in, sampled on rising clk.
- MISO  output  1  serial data out.
- rx_data  output  RX_W  deserialised word to RAM din; [9:8]=command, [7:0]=payload.
- rx_valid  output  1  one-cycle pulse, rx_data complete.
- tx_data  input  TX_W  read byte from RAM.
- tx_valid  input  1  tx_data valid (RAM level, held while RAM decodes 2'b11).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset state: state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift register=0.

States:
- IDLE: MISO=0, counter cleared. SS_n=0 -> CHK_CMD.
- CHK_CMD: if SS_n=1 -> IDLE. Otherwise sample MOSI:
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
  - This select bit is not stored in rx_data.
- WRITE / READ_ADD: shift MOSI into rx shift register MSB first, one bit per clk, 10 bits (counter 0..9).
  - On the edge sampling bit 9: rx_data <= full word and rx_valid <= 1.
  - rx_valid is high for exactly the following cycle, then 0.
  - Remain in state, MISO=0, until SS_n=1.
  - READ_ADD completion sets rd_addr_seen=1.
- READ_DATA, three phases:
  - (a) Shift 10 bits exactly as above (payload typically 2'b11 + 8 dummy bits); rx_valid pulses once.
  - (b) Wait for tx_valid=1 on any cycle after the rx_valid cycle. On that edge, load tx_data into the tx shift register.
  - (c) Drive MISO = tx_data[7] on the first cycle after the load, then [6] .. [0] on successive cycles (8 cycles).
  - After bit 0: MISO=0 and rd_addr_seen cleared; hold until SS_n=1.
  - tx_valid seen before the rx_valid cycle is ignored.
- Any state, SS_n=1 -> IDLE on the next edge:
  - Partial frame discarded; no rx_valid.
  - rd_addr_seen unchanged unless the frame fully completed its update point.
  - MISO=0.
- rx_data holds its last value between frames. It changes only at frame completion.
- MOSI bits after the 10th in WRITE/READ_ADD are ignored.
- rd_addr_seen toggles only on completed READ_ADD / fully shifted READ_DATA frames.
- Command bits [9:8] are forwarded unchecked; the RAM decodes them.
- Reset mid-frame: immediate return to reset state; MISO=0 combinationally with reset.

Decomposition:
- Shared package spi_ram_pkg:
  - State encoding localparams (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - RX_W/TX_W defaults.
- Single module; no sub-module needed.
- Serial-in and serial-out shifters are internal registers sharing one 4-bit counter.

Test Plan:
- Reset: assert rst_n=0 mid-activity -> MISO=0, rx_valid=0, rx_data=0 immediately; state IDLE after release.
- Write address:
  - Stimulus: SS_n=0, select bit 0, payload 10'b00_1010_0101.
  - Response: rx_data=10'h0A5 and a single rx_valid pulse the cycle after bit 9; MISO stays 0.
- Write data:
  - Stimulus: SS_n=0, select bit 0, payload 10'b01_1111_0000.
  - Response: rx_data=10'h1F0, one rx_valid pulse; rd_addr_seen unchanged.
- Read address then read data:
  - Frame 1: select bit 1, payload 10'b10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1.
  - Frame 2: select bit 1, payload 10'b11_0000_0000 -> rx_valid pulse.
  - Bench RAM model returns tx_valid=1, tx_data=8'hC3 the next cycle.
  - Response: MISO=1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0; rd_addr_seen=0.
- Aborted frame:
  - Stimulus: SS_n rises after 5 payload bits of a READ_ADD frame.
  - Response: no rx_valid, rx_data unchanged, rd_addr_seen stays 0; the next select bit 1 goes to READ_ADD.
- Late tx_valid:
  - Stimulus: tx_valid held 0 for 6 cycles after rx_valid in READ_DATA, then tx_data=8'h81.
  - Response: MISO idle 0 during the wait, then 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave front end and the single-port RAM behind it:
// word widths, FSM state encoding and the command codes carried in rx_data[9:8].
package spi_ram_pkg;

   localparam int RX_W  = 10;
   localparam int TX_W  = 8;
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// Bundle of the serial pins and the parallel RAM-side handshake of the SPI slave.
interface spi_slave_if_if;
   import spi_ram_pkg::*;

   logic            SS_n;
   logic            MOSI;
   logic            MISO;
   logic [RX_W-1:0] rx_data;
   logic            rx_valid;
   logic [TX_W-1:0] tx_data;
   logic            tx_valid;

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );

endinterface

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises 10-bit command/data frames for the RAM and, on read-data
// frames, serialises the returned RAM byte onto MISO MSB first.
module spi_slave_if
   import spi_ram_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   spi_slave_if_if.slave bus
);

   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);

   state_e           state_q,        state_d;
   logic [CNT_W-1:0] cnt_q,          cnt_d;
   logic [RX_W-1:0]  rx_shift_q,     rx_shift_d;
   logic [RX_W-1:0]  rx_data_q,      rx_data_d;
   logic             rx_valid_q,     rx_valid_d;
   logic             rx_done_q,      rx_done_d;
   logic [TX_W-1:0]  tx_shift_q,     tx_shift_d;
   logic             tx_busy_q,      tx_busy_d;
   logic             tx_done_q,      tx_done_d;
   logic             rd_addr_seen_q, rd_addr_seen_d;
   logic [RX_W-1:0]  rx_word;

   assign rx_word = {rx_shift_q[RX_W-2:0], bus.MOSI};

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d        = state_q;
      cnt_d          = cnt_q;
      rx_shift_d     = rx_shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rx_done_d      = rx_done_q;
      tx_shift_d     = tx_shift_q;
      tx_busy_d      = tx_busy_q;
      tx_done_d      = tx_done_q;
      rd_addr_seen_d = rd_addr_seen_q;

      if (bus.SS_n) begin
         // Deselect abandons any partial frame; rd_addr_seen only moves at completion points.
         state_d   = IDLE;
         cnt_d     = '0;
         rx_done_d = 1'b0;
         tx_busy_d = 1'b0;
         tx_done_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = CHK_CMD;
               cnt_d     = '0;
               rx_done_d = 1'b0;
               tx_busy_d = 1'b0;
               tx_done_d = 1'b0;
            end
            CHK_CMD: begin
               if (!bus.MOSI)          state_d = WRITE;
               else if (rd_addr_seen_q) state_d = READ_DATA;
               else                    state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (!rx_done_q) begin
                  rx_shift_d = rx_word;
                  if (cnt_q == RX_LAST) begin
                     rx_data_d  = rx_word;
                     rx_valid_d = 1'b1;
                     rx_done_d  = 1'b1;
                     cnt_d      = '0;
                     if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (state_q == READ_DATA) begin
                  if (tx_busy_q) begin
                     if (cnt_q == TX_LAST) begin
                        tx_busy_d      = 1'b0;
                        tx_done_d      = 1'b1;
                        rd_addr_seen_d = 1'b0;
                     end else begin
                        cnt_d      = cnt_q + 1'b1;
                        tx_shift_d = {tx_shift_q[TX_W-2:0], 1'b0};
                     end
                  end else if (!tx_done_q && !rx_valid_q && bus.tx_valid) begin
                     // tx_valid during the rx_valid cycle still belongs to the previous RAM access.
                     tx_shift_d = bus.tx_data;
                     tx_busy_d  = 1'b1;
                     cnt_d      = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rx_done_q      <= 1'b0;
         tx_shift_q     <= '0;
         tx_busy_q      <= 1'b0;
         tx_done_q      <= 1'b0;
         rd_addr_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rx_shift_q     <= rx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rx_done_q      <= rx_done_d;
         tx_shift_q     <= tx_shift_d;
         tx_busy_q      <= tx_busy_d;
         tx_done_q      <= tx_done_d;
         rd_addr_seen_q <= rd_addr_seen_d;
      end
   end

   // MISO is a pure function of reset-cleared flops, so it drops to 0 as soon as rst_n falls.
   assign bus.MISO     = tx_busy_q & tx_shift_q[TX_W-1];
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-address/read-data, abort, late tx_valid
// and mid-frame reset, with hand-computed expectations.
module tb_spi_slave_if;
   import spi_ram_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   pulses = 0;
   logic miso_seen = 1'b0;

   spi_slave_if_if bus ();

   spi_slave_if dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and sample outputs 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.rx_valid) pulses++;
      if (bus.MISO)     miso_seen = 1'b1;
   endtask

   task automatic start_frame(input logic sel);
      pulses    = 0;
      miso_seen = 1'b0;
      bus.SS_n  = 1'b0;
      tick();
      bus.MOSI  = sel;
      tick();
   endtask

   task automatic shift_word(input logic [RX_W-1:0] w);
      for (int i = RX_W - 1; i >= 0; i--) begin
         bus.MOSI = w[i];
         tick();
      end
   endtask

   task automatic end_frame();
      bus.SS_n = 1'b1;
      bus.MOSI = 1'b0;
      tick();
   endtask

   // Entered in the rx_valid cycle; RAM answers after wait_cycles idle cycles.
   task automatic serve_read(input string tag, input logic [TX_W-1:0] b, input int wait_cycles);
      tick();
      bus.tx_valid = 1'b0;
      for (int i = 0; i < wait_cycles; i++) begin
         check({tag, "_wait_miso"}, 32'(bus.MISO), 32'd0);
         tick();
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      tick();
      bus.tx_valid = 1'b0;
      for (int i = TX_W - 1; i >= 0; i--) begin
         check($sformatf("%s_miso_b%0d", tag, i), 32'(bus.MISO), 32'(b[i]));
         tick();
      end
      check({tag, "_miso_after"}, 32'(bus.MISO), 32'd0);
   endtask

   initial begin
      logic [RX_W-1:0] w;
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;

      tick();
      tick();
      check("rst_miso",     32'(bus.MISO),              32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid),          32'd0);
      check("rst_rx_data",  32'(bus.rx_data),           32'd0);
      check("rst_state",    32'(dut.state_q),           32'(IDLE));
      check("rst_rd_seen",  32'(dut.rd_addr_seen_q),    32'd0);
      rst_n = 1'b1;
      tick();

      // Write address 0x0A5; trailing MOSI bits must be ignored.
      w = {CMD_WR_ADDR, 8'hA5};
      start_frame(1'b0);
      check("wa_state", 32'(dut.state_q), 32'(WRITE));
      shift_word(w);
      check("wa_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("wa_rx_data",  32'(bus.rx_data),  32'h0A5);
      bus.MOSI = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("wa_rx_valid_low", 32'(bus.rx_valid), 32'd0);
      check("wa_rx_data_hold", 32'(bus.rx_data),  32'h0A5);
      check("wa_pulses",       32'(pulses),       32'd1);
      check("wa_miso_quiet",   32'(miso_seen),    32'd0);
      end_frame();

      // Write data 0x1F0.
      w = {CMD_WR_DATA, 8'hF0};
      start_frame(1'b0);
      shift_word(w);
      check("wd_rx_data", 32'(bus.rx_data), 32'h1F0);
      tick();
      check("wd_pulses",  32'(pulses),              32'd1);
      check("wd_rd_seen", 32'(dut.rd_addr_seen_q),  32'd0);
      end_frame();

      // Read address 0x203 then read data returning 0xC3.
      w = {CMD_RD_ADDR, 8'h03};
      start_frame(1'b1);
      check("ra_state", 32'(dut.state_q), 32'(READ_ADD));
      shift_word(w);
      check("ra_rx_data", 32'(bus.rx_data),         32'h203);
      check("ra_rd_seen", 32'(dut.rd_addr_seen_q),  32'd1);
      end_frame();
      w = {CMD_RD_DATA, 8'h00};
      start_frame(1'b1);
      check("rd_state", 32'(dut.state_q), 32'(READ_DATA));
      shift_word(w);
      check("rd_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("rd_rx_data",  32'(bus.rx_data),  32'h300);
      serve_read("rd", 8'hC3, 0);
      check("rd_pulses",  32'(pulses),             32'd1);
      check("rd_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
      end_frame();

      // Aborted READ_ADD after 5 payload bits.
      start_frame(1'b1);
      for (int i = 0; i < 5; i++) begin
         bus.MOSI = i[0];
         tick();
      end
      end_frame();
      check("ab_pulses",  32'(pulses),             32'd0);
      check("ab_rx_data", 32'(bus.rx_data),        32'h300);
      check("ab_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
      w = {CMD_RD_ADDR, 8'hAB};
      start_frame(1'b1);
      check("ab_next_state", 32'(dut.state_q), 32'(READ_ADD));
      shift_word(w);
      check("ab_next_rx_data", 32'(bus.rx_data),         32'h2AB);
      check("ab_next_rd_seen", 32'(dut.rd_addr_seen_q),  32'd1);
      end_frame();

      // Late tx_valid; an early tx_valid during shifting and the rx_valid cycle is ignored.
      w = {CMD_RD_DATA, 8'hA5};
      start_frame(1'b1);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      shift_word(w);
      check("lt_rx_data",   32'(bus.rx_data),  32'h3A5);
      check("lt_early_miso", 32'(miso_seen),   32'd0);
      serve_read("lt", 8'h81, 6);
      check("lt_pulses",  32'(pulses),             32'd1);
      check("lt_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
      end_frame();

      // Reset while MISO is driving a 1.
      start_frame(1'b1);
      shift_word({CMD_RD_ADDR, 8'hFF});
      end_frame();
      start_frame(1'b1);
      shift_word({CMD_RD_DATA, 8'h00});
      tick();
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hC3;
      tick();
      bus.tx_valid = 1'b0;
      check("mr_miso_before", 32'(bus.MISO), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_miso",     32'(bus.MISO),             32'd0);
      check("mr_rx_valid", 32'(bus.rx_valid),         32'd0);
      check("mr_rx_data",  32'(bus.rx_data),          32'd0);
      check("mr_rd_seen",  32'(dut.rd_addr_seen_q),   32'd0);
      rst_n = 1'b1;
      end_frame();
      check("mr_state", 32'(dut.state_q), 32'(IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
